// File: rtl/load_store_buffer.sv
// In-order load/store buffer. Decode allocates entries at the tail. The LS
// reservation station fills in addresses and data by ROB tag. The head entry
// executes through a single-outstanding memory port. A store is only allowed
// to reach memory after the ROB has committed it.
module load_store_buffer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _alloc_valid,
  input  logic        _alloc_store,
  input  logic [2:0]  _alloc_funct3,
  input  logic [4:0]  _alloc_rob_id,
  output logic        _lsb_full,
  input  logic        _lsb_rs_ready,
  input  logic [4:0]  _lsb_rob_id,
  input  logic [31:0] _lsb_st_value,
  input  logic [31:0] _lsb_ptr_value,
  input  logic        _rob_commit,
  input  logic [4:0]  _rob_commit_id,
  output logic        _st_ready,
  output logic [4:0]  _st_rob_id,
  output logic        _mem_req,
  output logic        _mem_we,
  output logic [31:0] _mem_addr,
  output logic [1:0]  _mem_size,
  output logic [31:0] _mem_wdata,
  input  logic        _mem_done,
  input  logic [31:0] _mem_rdata,
  output logic        _cdb_ls_ready,
  output logic [4:0]  _cdb_ls_rob_id,
  output logic [31:0] _cdb_ls_value
);

  localparam int CW = IDX_W + 1;
  typedef logic [CW-1:0]    cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic        valid;
    logic        store;
    logic [2:0]  funct3;
    logic [4:0]  rob_id;
    logic [31:0] addr;
    logic [31:0] data;
    logic        addr_ok;
    logic        committed;
  } entry_t;

  typedef enum logic {IDLE, WAIT} state_t;

  entry_t ent [DEPTH];
  idx_t   head, tail;
  cnt_t   count, ncommit;
  state_t state;

  // Attributes of the op that currently owns the memory port.
  logic       cur_store;
  logic [2:0] cur_funct3;
  logic [4:0] cur_rob;
  // Set when a flush hits an in-flight load. Its completion then neither
  // pops nor broadcasts, because the flush already discarded the entry.
  logic       squashed;

  entry_t hd;
  logic   can_issue, done, pop, pop_store, do_alloc;
  logic   commit_hit, fill_store;

  // Sign- or zero-extend raw LSB-aligned load data by funct3.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Clear the store-data bits above the access size.
  function automatic logic [31:0] size_mask(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {24'h0, d[7:0]};
      2'd1:    return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign _lsb_full = (count == cnt_t'(DEPTH));

  assign hd        = ent[head];
  assign can_issue = hd.valid && hd.addr_ok && (!hd.store || hd.committed);
  assign done      = (state == WAIT) && _mem_done;
  // A flushed load leaves nothing to pop, whether the flush came earlier or
  // arrives in the same cycle as the completion.
  assign pop       = done && (cur_store || !(squashed || _clear));
  assign pop_store = done && cur_store;
  assign do_alloc  = _alloc_valid && !_lsb_full && !_clear;

  // Tag match for commits and for store fills (which raise st_ready).
  always_comb begin
    commit_hit = 1'b0;
    fill_store = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (_rob_commit && ent[i].valid && ent[i].store && !ent[i].committed &&
          ent[i].rob_id == _rob_commit_id)
        commit_hit = 1'b1;
      if (_lsb_rs_ready && ent[i].valid && ent[i].store &&
          ent[i].rob_id == _lsb_rob_id)
        fill_store = 1'b1;
    end
  end

  // Head/tail pointers and occupancy counters. A flush keeps only the
  // committed-store prefix at the head.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ncommit <= '0;
    end else if (rdy_in) begin
      if (_clear) begin
        tail    <= head + ncommit[IDX_W-1:0];
        count   <= ncommit - cnt_t'(pop_store);
        ncommit <= ncommit - cnt_t'(pop_store);
      end else begin
        if (do_alloc) tail <= tail + idx_t'(1);
        count   <= count + cnt_t'(do_alloc) - cnt_t'(pop);
        ncommit <= ncommit + cnt_t'(commit_hit) - cnt_t'(pop_store);
      end
      if (pop) head <= head + idx_t'(1);
    end
  end

  // Per-entry state: allocate, fill, commit, flush and retire.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (_clear) begin
          if (!ent[i].committed) begin
            ent[i].valid   <= 1'b0;
            ent[i].addr_ok <= 1'b0;
          end
        end else begin
          if (_lsb_rs_ready && ent[i].valid && ent[i].rob_id == _lsb_rob_id) begin
            ent[i].addr    <= _lsb_ptr_value;
            ent[i].data    <= _lsb_st_value;
            ent[i].addr_ok <= 1'b1;
          end
          if (_rob_commit && ent[i].valid && ent[i].store &&
              ent[i].rob_id == _rob_commit_id)
            ent[i].committed <= 1'b1;
        end
        if (pop && head == idx_t'(i)) begin
          ent[i].valid     <= 1'b0;
          ent[i].addr_ok   <= 1'b0;
          ent[i].committed <= 1'b0;
        end
        if (do_alloc && tail == idx_t'(i)) begin
          ent[i].valid     <= 1'b1;
          ent[i].store     <= _alloc_store;
          ent[i].funct3    <= _alloc_funct3;
          ent[i].rob_id    <= _alloc_rob_id;
          ent[i].addr      <= '0;
          ent[i].data      <= '0;
          ent[i].addr_ok   <= 1'b0;
          ent[i].committed <= 1'b0;
        end
      end
    end
  end

  // One-cycle store-address-ready pulse toward the ROB.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      _st_ready  <= 1'b0;
      _st_rob_id <= '0;
    end else if (rdy_in) begin
      _st_ready <= 1'b0;
      if (!_clear && fill_store) begin
        _st_ready  <= 1'b1;
        _st_rob_id <= _lsb_rob_id;
      end
    end
  end

  // Memory port FSM with registered request and CDB outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      _mem_req       <= 1'b0;
      _mem_we        <= 1'b0;
      _mem_addr      <= '0;
      _mem_size      <= '0;
      _mem_wdata     <= '0;
      _cdb_ls_ready  <= 1'b0;
      _cdb_ls_rob_id <= '0;
      _cdb_ls_value  <= '0;
      cur_store      <= 1'b0;
      cur_funct3     <= '0;
      cur_rob        <= '0;
      squashed       <= 1'b0;
    end else if (rdy_in) begin
      _cdb_ls_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Skip issue during a flush. The head may be the op being discarded.
          if (can_issue && !_clear) begin
            _mem_req   <= 1'b1;
            _mem_we    <= hd.store;
            _mem_addr  <= hd.addr;
            _mem_size  <= hd.funct3[1:0];
            _mem_wdata <= size_mask(hd.funct3[1:0], hd.data);
            cur_store  <= hd.store;
            cur_funct3 <= hd.funct3;
            cur_rob    <= hd.rob_id;
            squashed   <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (_mem_done) begin
            _mem_req <= 1'b0;
            state    <= IDLE;
            squashed <= 1'b0;
            if (!cur_store && !squashed && !_clear) begin
              _cdb_ls_ready  <= 1'b1;
              _cdb_ls_rob_id <= cur_rob;
              _cdb_ls_value  <= load_ext(cur_funct3, _mem_rdata);
            end
          end else if (_clear && !cur_store) begin
            squashed <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// Scoreboard bench for load_store_buffer. Stimulus pushes the expected memory
// requests, CDB results and st_ready pulses into queues. Independent monitors
// pop and compare whenever the DUT presents an output. A memory responder
// answers each request after mem_lat cycles.
module tb_load_store_buffer;

  logic        clk_in = 0, rst_in = 0, rdy_in = 1, _clear = 0;
  logic        _alloc_valid = 0, _alloc_store = 0;
  logic [2:0]  _alloc_funct3 = 0;
  logic [4:0]  _alloc_rob_id = 0;
  logic        _lsb_full;
  logic        _lsb_rs_ready = 0;
  logic [4:0]  _lsb_rob_id = 0;
  logic [31:0] _lsb_st_value = 0, _lsb_ptr_value = 0;
  logic        _rob_commit = 0;
  logic [4:0]  _rob_commit_id = 0;
  logic        _st_ready;
  logic [4:0]  _st_rob_id;
  logic        _mem_req, _mem_we;
  logic [31:0] _mem_addr, _mem_wdata;
  logic [1:0]  _mem_size;
  logic        _mem_done = 0;
  logic [31:0] _mem_rdata = 0;
  logic        _cdb_ls_ready;
  logic [4:0]  _cdb_ls_rob_id;
  logic [31:0] _cdb_ls_value;

  load_store_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._alloc_valid(_alloc_valid), ._alloc_store(_alloc_store),
    ._alloc_funct3(_alloc_funct3), ._alloc_rob_id(_alloc_rob_id),
    ._lsb_full(_lsb_full), ._lsb_rs_ready(_lsb_rs_ready), ._lsb_rob_id(_lsb_rob_id),
    ._lsb_st_value(_lsb_st_value), ._lsb_ptr_value(_lsb_ptr_value),
    ._rob_commit(_rob_commit), ._rob_commit_id(_rob_commit_id),
    ._st_ready(_st_ready), ._st_rob_id(_st_rob_id),
    ._mem_req(_mem_req), ._mem_we(_mem_we), ._mem_addr(_mem_addr),
    ._mem_size(_mem_size), ._mem_wdata(_mem_wdata), ._mem_done(_mem_done),
    ._mem_rdata(_mem_rdata), ._cdb_ls_ready(_cdb_ls_ready),
    ._cdb_ls_rob_id(_cdb_ls_rob_id), ._cdb_ls_value(_cdb_ls_value)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mreq_t;
  typedef struct {
    logic [4:0]  rob;
    logic [31:0] val;
  } cdb_t;

  mreq_t      mq[$];
  cdb_t       cq[$];
  logic [4:0] sq[$];
  int n_asrt = 0, n_fail = 0;
  int mem_lat = 2;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [31:0] rdata);
    mreq_t e;
    e.we = we; e.addr = addr; e.size = size; e.wdata = wdata; e.rdata = rdata;
    mq.push_back(e);
  endtask

  task automatic exp_cdb(input logic [4:0] rob, input logic [31:0] val);
    cdb_t e;
    e.rob = rob; e.val = val;
    cq.push_back(e);
  endtask

  task automatic alloc(input logic st, input logic [2:0] f3, input logic [4:0] rob);
    _alloc_valid = 1; _alloc_store = st; _alloc_funct3 = f3; _alloc_rob_id = rob;
    @(negedge clk_in);
    _alloc_valid = 0;
  endtask

  task automatic fill(input logic [4:0] rob, input logic [31:0] addr, input logic [31:0] data);
    _lsb_rs_ready = 1; _lsb_rob_id = rob; _lsb_ptr_value = addr; _lsb_st_value = data;
    @(negedge clk_in);
    _lsb_rs_ready = 0;
  endtask

  task automatic commit(input logic [4:0] rob);
    _rob_commit = 1; _rob_commit_id = rob;
    @(negedge clk_in);
    _rob_commit = 0;
  endtask

  task automatic flush();
    _clear = 1;
    @(negedge clk_in);
    _clear = 0;
  endtask

  // Bounded wait until every expectation has been consumed and the port is idle.
  task automatic wait_drain(input int bound, input string name);
    int k = 0;
    while ((mq.size() != 0 || cq.size() != 0 || sq.size() != 0 || _mem_req || _mem_done)
           && k < bound) begin
      @(negedge clk_in);
      k++;
    end
    repeat (3) @(negedge clk_in);
    chk({name, "_timeout"}, 32'(k < bound), 32'd1);
    chk({name, "_leftover"}, 32'(mq.size() + cq.size() + sq.size()), 32'd0);
  endtask

  // Memory responder and request checker.
  always begin
    mreq_t e;
    int lat;
    logic [31:0] rd;
    @(negedge clk_in);
    if (_mem_req) begin
      rd = 32'h0;
      if (mq.size() == 0) begin
        n_asrt++; n_fail++;
        $display("FAIL mem_unexpected: got request addr %h we %0d, expected none", _mem_addr, _mem_we);
      end else begin
        e = mq.pop_front();
        chk("mem_we", 32'(_mem_we), 32'(e.we));
        chk("mem_addr", _mem_addr, e.addr);
        chk("mem_size", 32'(_mem_size), 32'(e.size));
        if (e.we) chk("mem_wdata", _mem_wdata, e.wdata);
        rd = e.rdata;
      end
      lat = mem_lat;
      for (int k = 1; k < lat; k++) begin
        @(negedge clk_in);
        chk("mem_hold", 32'(_mem_req), 32'd1);
      end
      _mem_done = 1; _mem_rdata = rd;
      @(negedge clk_in);
      _mem_done = 0;
    end
  end

  // CDB result checker.
  always @(negedge clk_in) begin
    if (_cdb_ls_ready) begin
      if (cq.size() == 0) begin
        n_asrt++; n_fail++;
        $display("FAIL cdb_unexpected: got rob %0d value %h, expected no pulse", _cdb_ls_rob_id, _cdb_ls_value);
      end else begin
        cdb_t e;
        e = cq.pop_front();
        chk("cdb_rob", 32'(_cdb_ls_rob_id), 32'(e.rob));
        chk("cdb_value", _cdb_ls_value, e.val);
      end
    end
  end

  // Store-address-ready checker.
  always @(negedge clk_in) begin
    if (_st_ready) begin
      if (sq.size() == 0) begin
        n_asrt++; n_fail++;
        $display("FAIL st_unexpected: got rob %0d, expected no pulse", _st_rob_id);
      end else begin
        chk("st_rob", 32'(_st_rob_id), 32'(sq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_full", 32'(_lsb_full), 0);
    chk("rst_mem_req", 32'(_mem_req), 0);
    chk("rst_cdb", 32'(_cdb_ls_ready), 0);
    chk("rst_st", 32'(_st_ready), 0);
    chk("rst_addr", _mem_addr, 0);
    rst_in = 1;
    @(negedge clk_in);

    // Load byte, sign-extended.
    exp_mem(0, 32'h100, 2'd0, 32'h0, 32'h80);
    exp_cdb(5'd3, 32'hFFFFFF80);
    alloc(0, 3'b000, 5'd3);
    fill(5'd3, 32'h100, 32'h0);
    wait_drain(50, "t1");

    // Store waits for commit before writing.
    sq.push_back(5'd5);
    alloc(1, 3'b010, 5'd5);
    fill(5'd5, 32'h200, 32'h1234ABCD);
    repeat (6) @(negedge clk_in);
    exp_mem(1, 32'h200, 2'd2, 32'h1234ABCD, 32'h0);
    commit(5'd5);
    wait_drain(50, "t2");

    // Uncommitted half store blocks a later zero-extended half load.
    sq.push_back(5'd1);
    alloc(1, 3'b001, 5'd1);
    alloc(0, 3'b101, 5'd2);
    fill(5'd1, 32'h300, 32'hDEADBEEF);
    fill(5'd2, 32'h304, 32'h0);
    repeat (6) @(negedge clk_in);
    exp_mem(1, 32'h300, 2'd1, 32'h0000BEEF, 32'h0);
    exp_mem(0, 32'h304, 2'd1, 32'h0, 32'hABCDF00F);
    exp_cdb(5'd2, 32'h0000F00F);
    commit(5'd1);
    wait_drain(50, "t3");

    // Fill to full, drain 4, wrap with 4 more, out-of-order fills.
    for (int i = 0; i < 16; i++) alloc(0, 3'b010, 5'(i));
    chk("full_16", 32'(_lsb_full), 1);
    alloc(0, 3'b010, 5'd31);
    chk("full_ignored_alloc", 32'(_lsb_full), 1);
    for (int i = 0; i < 4; i++) begin
      exp_mem(0, 32'h1000 + 32'(4 * i), 2'd2, 32'h0, 32'h5A000000 + 32'(i));
      exp_cdb(5'(i), 32'h5A000000 + 32'(i));
    end
    for (int i = 0; i < 4; i++) fill(5'(i), 32'h1000 + 32'(4 * i), 32'h0);
    wait_drain(100, "t4a");
    chk("full_after_drain", 32'(_lsb_full), 0);
    for (int i = 16; i < 20; i++) alloc(0, 3'b010, 5'(i));
    chk("full_after_wrap", 32'(_lsb_full), 1);
    for (int i = 4; i < 20; i++) begin
      exp_mem(0, 32'h1000 + 32'(4 * i), 2'd2, 32'h0, 32'h5A000000 + 32'(i));
      exp_cdb(5'(i), 32'h5A000000 + 32'(i));
    end
    for (int i = 19; i >= 4; i--) fill(5'(i), 32'h1000 + 32'(4 * i), 32'h0);
    wait_drain(400, "t4b");
    chk("empty_after_wrap", 32'(_lsb_full), 0);

    // Flush with a committed store in flight and 3 uncommitted loads behind it.
    mem_lat = 30;
    sq.push_back(5'd7);
    alloc(1, 3'b010, 5'd7);
    alloc(0, 3'b010, 5'd8);
    alloc(0, 3'b010, 5'd9);
    alloc(0, 3'b010, 5'd10);
    fill(5'd7, 32'h400, 32'hCAFEF00D);
    exp_mem(1, 32'h400, 2'd2, 32'hCAFEF00D, 32'h0);
    commit(5'd7);
    repeat (2) @(negedge clk_in);
    flush();
    fill(5'd8, 32'h408, 32'h0);
    fill(5'd9, 32'h40C, 32'h0);
    fill(5'd10, 32'h410, 32'h0);
    for (int i = 11; i < 25; i++) alloc(0, 3'b010, 5'(i));
    chk("clr_count_15", 32'(_lsb_full), 0);
    alloc(0, 3'b010, 5'd25);
    chk("clr_count_16", 32'(_lsb_full), 1);
    wait_drain(60, "t5");
    chk("clr_store_popped", 32'(_lsb_full), 0);
    flush();
    mem_lat = 2;

    // Flush with a load in flight: completion accepted, no CDB, count 0.
    mem_lat = 10;
    exp_mem(0, 32'h500, 2'd0, 32'h0, 32'hFF);
    alloc(0, 3'b000, 5'd12);
    fill(5'd12, 32'h500, 32'h0);
    repeat (3) @(negedge clk_in);
    flush();
    wait_drain(40, "t6");
    for (int i = 0; i < 15; i++) alloc(0, 3'b010, 5'(i));
    chk("sq_count_15", 32'(_lsb_full), 0);
    alloc(0, 3'b010, 5'd15);
    chk("sq_count_16", 32'(_lsb_full), 1);
    flush();
    mem_lat = 2;

    // Pause: nothing is accepted while rdy_in is low.
    rdy_in = 0;
    alloc(0, 3'b010, 5'd20);
    fill(5'd20, 32'h700, 32'h0);
    rdy_in = 1;
    repeat (5) @(negedge clk_in);

    // Normal operation after flushes: zero-extend byte, sign-extend half.
    exp_mem(0, 32'h600, 2'd0, 32'h0, 32'h123456F0);
    exp_cdb(5'd30, 32'h000000F0);
    exp_mem(0, 32'h602, 2'd1, 32'h0, 32'h00008001);
    exp_cdb(5'd29, 32'hFFFF8001);
    alloc(0, 3'b100, 5'd30);
    alloc(0, 3'b001, 5'd29);
    fill(5'd29, 32'h602, 32'h0);
    fill(5'd30, 32'h600, 32'h0);
    wait_drain(60, "t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
